dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single synchronous data memory (`dmemory`, 1-cycle read latency, active-low `ceb`/`web`) between the pipeline MEM stage (port 0) and a secondary master such as the interrupt context-save engine or a debug/DMA agent (port 1). Port 0 wins by default. A starvation counter forces a port-1 grant after `MAX_WAIT` consecutive denied cycles. Read data is routed back one cycle later to the port that issued the read.

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_arbiter_starve_cnt.sv | 41 ++++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter: port indices,
// memory control encodings and the grant selector.
package dmem_arb_pkg;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  localparam int MAX_WAIT_DEFAULT = 4;

  localparam logic CEB_ON  = 1'b0;
  localparam logic CEB_OFF = 1'b1;
  localparam logic WEB_WR  = 1'b0;
  localparam logic WEB_RD  = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_P0   = 2'd1,
    SEL_P1   = 2'd2
  } arb_sel_e;

  // Byte enables only mean something on writes; reads present an all-zero mask.
  function automatic logic [3:0] access_mask(input logic we, input logic [3:0] mask);
    if (we) begin
      return mask;
    end else begin
      return 4'b0000;
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating starvation counter for the secondary port; hit flags that the
// configured limit of consecutive denials has been reached.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = 4'd0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt_nxt = cnt + 4'd1;
    end else begin
      cnt_nxt = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign hit = (cnt == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported synchronous data memory.
// Port 0 (MEM stage) has priority; port 1 is forced through after MAX_WAIT denials.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [3:0]    p0_mask,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [3:0]    p1_mask,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_ceb,
  output logic          mem_web,
  output logic [AW-1:0] mem_a,
  output logic [3:0]    mem_mask,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  arb_sel_e sel;
  logic     starve_hit;
  logic     rd_issue;
  logic     rd_pend;
  logic     rd_owner;

  arb_starve_cnt #(
    .MAX (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .resetn (resetn),
    .inc    (p1_req & ~p1_gnt),
    .clr    (p1_gnt | ~p1_req),
    .hit    (starve_hit)
  );

  // Grant selection: port 1 wins only when alone or when starved.
  always_comb begin
    sel = SEL_NONE;
    if (p1_req && (!p0_req || starve_hit)) begin
      sel = SEL_P1;
    end else if (p0_req) begin
      sel = SEL_P0;
    end else begin
      sel = SEL_NONE;
    end
  end

  assign p0_gnt   = (sel == SEL_P0);
  assign p1_gnt   = (sel == SEL_P1);
  assign rd_issue = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);

  // Memory request mux; an idle cycle drives a quiet, all-zero bus.
  always_comb begin
    mem_ceb  = CEB_OFF;
    mem_web  = WEB_RD;
    mem_a    = {AW{1'b0}};
    mem_mask = 4'b0000;
    mem_d    = {DW{1'b0}};
    case (sel)
      SEL_P0: begin
        mem_ceb  = CEB_ON;
        mem_web  = p0_we ? WEB_WR : WEB_RD;
        mem_a    = p0_addr;
        mem_mask = access_mask(p0_we, p0_mask);
        mem_d    = p0_wdata;
      end
      SEL_P1: begin
        mem_ceb  = CEB_ON;
        mem_web  = p1_we ? WEB_WR : WEB_RD;
        mem_a    = p1_addr;
        mem_mask = access_mask(p1_we, p1_mask);
        mem_d    = p1_wdata;
      end
      default: begin
        mem_ceb  = CEB_OFF;
        mem_web  = WEB_RD;
        mem_a    = {AW{1'b0}};
        mem_mask = 4'b0000;
        mem_d    = {DW{1'b0}};
      end
    endcase
  end

  // Read tracking: remembers whether last cycle issued a read and for whom.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pend  <= 1'b0;
      rd_owner <= ARB_P0;
    end else begin
      rd_pend <= rd_issue;
      if (sel == SEL_NONE) begin
        rd_owner <= rd_owner;
      end else begin
        rd_owner <= (sel == SEL_P1) ? ARB_P1 : ARB_P0;
      end
    end
  end

  // Gating with resetn drops a response whose cycle coincides with reset entry.
  always_comb begin
    p0_rvalid = resetn & rd_pend & (rd_owner == ARB_P0);
    p1_rvalid = resetn & rd_pend & (rd_owner == ARB_P1);
    if (p0_rvalid) begin
      p0_rdata = mem_q;
    end else begin
      p0_rdata = {DW{1'b0}};
    end
    if (p1_rvalid) begin
      p1_rdata = mem_q;
    end else begin
      p1_rdata = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [3:0]    p0_mask, p1_mask;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_ceb, mem_web;
  logic [AW-1:0] mem_a;
  logic [3:0]    mem_mask;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  logic          load_en;
  logic [DW-1:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_mask(p0_mask),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_mask(p1_mask),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_ceb(mem_ceb), .mem_web(mem_web), .mem_a(mem_a), .mem_mask(mem_mask),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  // Behavioural dmemory: 1-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h010] <= 32'hDEADBEEF;
      mem[10'h030] <= 32'h33334444;
      mem[10'h040] <= 32'h11112222;
      mem_q <= 32'h0;
    end else if (mem_ceb == 1'b0) begin
      if (mem_web == 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_a][b*8 +: 8] <= mem_d[b*8 +: 8];
      end else begin
        mem_q <= mem[mem_a];
      end
    end
  end

  typedef struct {
    logic p0r; logic p0w; logic [AW-1:0] p0a; logic [3:0] p0m; logic [DW-1:0] p0d;
    logic p1r; logic p1w; logic [AW-1:0] p1a; logic [3:0] p1m; logic [DW-1:0] p1d;
    logic g0; logic g1; logic ceb; logic web; logic [AW-1:0] a; logic [3:0] mask;
    logic rv0; logic rv1; logic [DW-1:0] rd0; logic [DW-1:0] rd1;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(
    logic p0r, logic p0w, logic [AW-1:0] p0a, logic [3:0] p0m, logic [DW-1:0] p0d,
    logic p1r, logic p1w, logic [AW-1:0] p1a, logic [3:0] p1m, logic [DW-1:0] p1d,
    logic g0, logic g1, logic ceb, logic web, logic [AW-1:0] a, logic [3:0] mask,
    logic rv0, logic rv1, logic [DW-1:0] rd0, logic [DW-1:0] rd1);
    vec_t v;
    v.p0r = p0r; v.p0w = p0w; v.p0a = p0a; v.p0m = p0m; v.p0d = p0d;
    v.p1r = p1r; v.p1w = p1w; v.p1a = p1a; v.p1m = p1m; v.p1d = p1d;
    v.g0 = g0; v.g1 = g1; v.ceb = ceb; v.web = web; v.a = a; v.mask = mask;
    v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [3:0] m0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1,
                       input logic [3:0] m1, input logic [DW-1:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_mask = m0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_mask = m1; p1_wdata = d1;
  endtask

  // One cycle with both ports reading fixed addresses; only the grants are checked.
  task automatic hcyc(input string nm, input logic r0, input logic r1,
                      input logic eg0, input logic eg1);
    drive(r0, 1'b0, 10'h030, 4'h0, 32'h0, r1, 1'b0, 10'h040, 4'h0, 32'h0);
    @(negedge clk);
    chk({nm, "_p0_gnt"}, p0_gnt, eg0);
    chk({nm, "_p1_gnt"}, p1_gnt, eg1);
    @(posedge clk); #1;
  endtask

  // Reference model state: port-1 denial streak, outstanding read, shadow memory.
  int            streak;
  logic          m_pend, m_owner;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] shadow [0:1023];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic eg0, eg1, e_ceb, e_web, e_rv0, e_rv1;
    logic [AW-1:0] e_a;
    logic [3:0] e_mask;
    logic [DW-1:0] e_d;

    resetn = 1'b0;
    load_en = 1'b1;
    drive(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
    load_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_p0_rvalid", p0_rvalid, 1'b0);
    chk("rst_p1_rvalid", p1_rvalid, 1'b0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_p1_rdata", p1_rdata, 32'h0);
    chk("rst_mem_ceb", mem_ceb, 1'b1);
    chk("rst_mem_web", mem_web, 1'b1);
    chk("rst_mem_a", mem_a, 10'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    tbl[0]  = mk(1,0,10'h010,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0,         1,0,0,1,10'h010,4'h0, 0,0,32'h0,32'h0);
    tbl[1]  = mk(0,0,10'h000,4'h0,32'h0, 1,1,10'h020,4'h3,32'h0000ABCD,  0,1,0,0,10'h020,4'h3, 1,0,32'hDEADBEEF,32'h0);
    tbl[2]  = mk(0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0,         0,0,1,1,10'h000,4'h0, 0,0,32'h0,32'h0);
    tbl[3]  = mk(1,0,10'h020,4'hF,32'h0, 0,0,10'h000,4'h0,32'h0,         1,0,0,1,10'h020,4'h0, 0,0,32'h0,32'h0);
    tbl[4]  = mk(0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0,         0,0,1,1,10'h000,4'h0, 1,0,32'h0000ABCD,32'h0);
    tbl[5]  = mk(1,0,10'h030,4'h0,32'h0, 1,0,10'h040,4'h0,32'h0,         1,0,0,1,10'h030,4'h0, 0,0,32'h0,32'h0);
    tbl[6]  = mk(1,0,10'h030,4'h0,32'h0, 1,0,10'h040,4'h0,32'h0,         1,0,0,1,10'h030,4'h0, 1,0,32'h33334444,32'h0);
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = mk(1,0,10'h030,4'h0,32'h0, 1,0,10'h040,4'h0,32'h0,         0,1,0,1,10'h040,4'h0, 1,0,32'h33334444,32'h0);
    tbl[10] = mk(1,0,10'h030,4'h0,32'h0, 1,0,10'h040,4'h0,32'h0,         1,0,0,1,10'h030,4'h0, 0,1,32'h0,32'h11112222);
    tbl[11] = mk(0,0,10'h000,4'h0,32'h0, 0,0,10'h000,4'h0,32'h0,         0,0,1,1,10'h000,4'h0, 1,0,32'h33334444,32'h0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].p0r, tbl[i].p0w, tbl[i].p0a, tbl[i].p0m, tbl[i].p0d,
            tbl[i].p1r, tbl[i].p1w, tbl[i].p1a, tbl[i].p1m, tbl[i].p1d);
      @(negedge clk);
      chk($sformatf("tbl%0d_p0_gnt", i), p0_gnt, tbl[i].g0);
      chk($sformatf("tbl%0d_p1_gnt", i), p1_gnt, tbl[i].g1);
      chk($sformatf("tbl%0d_mem_ceb", i), mem_ceb, tbl[i].ceb);
      chk($sformatf("tbl%0d_mem_web", i), mem_web, tbl[i].web);
      chk($sformatf("tbl%0d_mem_a", i), mem_a, tbl[i].a);
      chk($sformatf("tbl%0d_mem_mask", i), mem_mask, tbl[i].mask);
      chk($sformatf("tbl%0d_p0_rvalid", i), p0_rvalid, tbl[i].rv0);
      chk($sformatf("tbl%0d_p1_rvalid", i), p1_rvalid, tbl[i].rv1);
      chk($sformatf("tbl%0d_p0_rdata", i), p0_rdata, tbl[i].rd0);
      chk($sformatf("tbl%0d_p1_rdata", i), p1_rdata, tbl[i].rd1);
      @(posedge clk); #1;
    end

    // Port 1 drops after 3 denials: the streak restarts and needs 4 more.
    for (int i = 0; i < 3; i++) hcyc("drop_pre", 1'b1, 1'b1, 1'b1, 1'b0);
    hcyc("drop_gap", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) hcyc("drop_deny", 1'b1, 1'b1, 1'b1, 1'b0);
    hcyc("drop_force", 1'b1, 1'b1, 1'b0, 1'b1);
    hcyc("drop_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset right after a granted read, with a partly built streak.
    hcyc("rst_pre", 1'b1, 1'b1, 1'b1, 1'b0);
    hcyc("rst_pre", 1'b1, 1'b1, 1'b1, 1'b0);
    hcyc("rst_rd", 1'b1, 1'b1, 1'b1, 1'b0);
    resetn = 1'b0;
    drive(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_drop_p0_rvalid", p0_rvalid, 1'b0);
    chk("rst_drop_p0_rdata", p0_rdata, 32'h0);
    chk("rst_drop_p1_rvalid", p1_rvalid, 1'b0);
    @(posedge clk); #1;
    hcyc("rst_hold", 1'b1, 1'b1, 1'b1, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) hcyc("rst_post", 1'b1, 1'b1, 1'b1, 1'b0);
    hcyc("rst_force", 1'b1, 1'b1, 1'b0, 1'b1);
    hcyc("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized run against the reference model, starting from a fresh reset.
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    streak = 0; m_pend = 1'b0; m_owner = 1'b0; m_rd = 32'h0;
    for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
    eg0 = 1'b0; eg1 = 1'b0;
    drive(1'b0, 1'b0, 10'h0, 4'h0, 32'h0, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);

    for (int c = 0; c < 600; c++) begin
      if (!(p0_req && !eg0 && ($urandom_range(0, 9) != 0))) begin
        p0_req = ($urandom_range(0, 99) < 70);
        p0_we = 1'($urandom_range(0, 1));
        p0_addr = 10'h100 + 10'($urandom_range(0, 15));
        p0_mask = 4'($urandom);
        p0_wdata = $urandom;
      end
      if (!(p1_req && !eg1 && ($urandom_range(0, 9) != 0))) begin
        p1_req = ($urandom_range(0, 99) < 50);
        p1_we = 1'($urandom_range(0, 1));
        p1_addr = 10'h100 + 10'($urandom_range(0, 15));
        p1_mask = 4'($urandom);
        p1_wdata = $urandom;
      end

      @(negedge clk);
      eg1 = p1_req && (!p0_req || (streak >= MW));
      eg0 = p0_req && !eg1;
      e_ceb = 1'b1; e_web = 1'b1; e_a = 10'h0; e_mask = 4'h0; e_d = 32'h0;
      if (eg0) begin
        e_ceb = 1'b0; e_web = ~p0_we; e_a = p0_addr;
        e_mask = p0_we ? p0_mask : 4'h0; e_d = p0_wdata;
      end else if (eg1) begin
        e_ceb = 1'b0; e_web = ~p1_we; e_a = p1_addr;
        e_mask = p1_we ? p1_mask : 4'h0; e_d = p1_wdata;
      end
      e_rv0 = m_pend && (m_owner == 1'b0);
      e_rv1 = m_pend && (m_owner == 1'b1);
      chk("rnd_p0_gnt", p0_gnt, eg0);
      chk("rnd_p1_gnt", p1_gnt, eg1);
      chk("rnd_mem_ceb", mem_ceb, e_ceb);
      chk("rnd_mem_web", mem_web, e_web);
      chk("rnd_mem_a", mem_a, e_a);
      chk("rnd_mem_mask", mem_mask, e_mask);
      chk("rnd_mem_d", mem_d, e_d);
      chk("rnd_p0_rvalid", p0_rvalid, e_rv0);
      chk("rnd_p1_rvalid", p1_rvalid, e_rv1);
      chk("rnd_p0_rdata", p0_rdata, e_rv0 ? m_rd : 32'h0);
      chk("rnd_p1_rdata", p1_rdata, e_rv1 ? m_rd : 32'h0);

      @(posedge clk);
      m_pend = 1'b0;
      if (eg0 && !p0_we) begin
        m_pend = 1'b1; m_owner = 1'b0; m_rd = shadow[p0_addr];
      end else if (eg1 && !p1_we) begin
        m_pend = 1'b1; m_owner = 1'b1; m_rd = shadow[p1_addr];
      end
      for (int b = 0; b < 4; b++) begin
        if (eg0 && p0_we && p0_mask[b]) shadow[p0_addr][b*8 +: 8] = p0_wdata[b*8 +: 8];
        if (eg1 && p1_we && p1_mask[b]) shadow[p1_addr][b*8 +: 8] = p1_wdata[b*8 +: 8];
      end
      if (p1_req && !eg1) streak = (streak + 1 > MW) ? MW : streak + 1;
      else streak = 0;
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
